// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 16x majority sampling (clk, rstn, Baudrate_Set, uart_rx -> data, Rx_Done, frame_err, busy)
module uart_rx_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] Baudrate_Set,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       Rx_Done,
  output logic       frame_err,
  output logic       busy
);
  localparam int D0 = CLK_FREQ / (9600 * OSR) - 1;
  localparam int D1 = CLK_FREQ / (19200 * OSR) - 1;
  localparam int D2 = CLK_FREQ / (38400 * OSR) - 1;
  localparam int D3 = CLK_FREQ / (57600 * OSR) - 1;
  localparam int D4 = CLK_FREQ / (115200 * OSR) - 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t st;
  logic s1, s2, prev, tick, fall, maj, mid, last;
  logic [15:0] div, cnt, div_sel;
  logic [3:0] s;
  logic [2:0] bc;
  logic [1:0] smp;
  logic [7:0] sh;
  always_comb begin
    div_sel = Baudrate_Set == 3'd1 ? 16'(D1) :
              Baudrate_Set == 3'd2 ? 16'(D2) :
              Baudrate_Set == 3'd3 ? 16'(D3) :
              Baudrate_Set == 3'd4 ? 16'(D4) : 16'(D0);
    tick = cnt == div;
    fall = prev & ~s2;
    maj = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
    mid = tick && s == 4'd8;
    last = tick && s == 4'd15;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      st <= IDLE;
      div <= '0;
      cnt <= '0;
      s <= '0;
      bc <= '0;
      smp <= '0;
      sh <= '0;
      data <= '0;
      Rx_Done <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      prev <= s2;
      Rx_Done <= 1'b0;
      frame_err <= 1'b0;
      if (st != IDLE) begin
        cnt <= tick ? '0 : cnt + 16'd1;
        if (tick) s <= s + 4'd1;
        if (tick && (s == 4'd6 || s == 4'd7)) smp <= {smp[0], s2};
      end
      case (st)
        IDLE: begin
          busy <= 1'b0;
          if (fall) begin
            st <= START;
            cnt <= '0;
            s <= '0;
            div <= div_sel;
            busy <= 1'b1;
          end
        end
        START: begin
          if (mid && maj) begin
            st <= IDLE;
            busy <= 1'b0;
          end else if (last) begin
            st <= DATA;
            bc <= '0;
          end
        end
        DATA: begin
          if (mid) sh <= {maj, sh[7:1]};
          if (last) begin
            bc <= bc + 3'd1;
            if (bc == 3'd7) st <= STOP;
          end
        end
        STOP: begin
          if (mid) begin
            st <= IDLE;
            busy <= 1'b0;
            if (maj) begin
              data <= sh;
              Rx_Done <= 1'b1;
            end else frame_err <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core at a 10 MHz clock
module tb_uart_rx_core;
  localparam int BP4 = 80;
  localparam int BP0 = 1040;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [2:0] Baudrate_Set = 3'd4;
  logic uart_rx = 1'b1;
  logic [7:0] data;
  logic Rx_Done, frame_err, busy;
  int total = 0, passed = 0;
  int done_cnt = 0, err_cnt = 0, viol = 0, busy_low = 0;
  logic pd = 1'b0, pe = 1'b0, mid_frame = 1'b0;
  int d0, e0;
  uart_rx_core #(.CLK_FREQ(10_000_000)) dut (
    .clk(clk), .rstn(rstn), .Baudrate_Set(Baudrate_Set), .uart_rx(uart_rx),
    .data(data), .Rx_Done(Rx_Done), .frame_err(frame_err), .busy(busy)
  );
  always #50 clk = ~clk;
  always @(negedge clk) begin
    if (Rx_Done) done_cnt++;
    if (frame_err) err_cnt++;
    if ((Rx_Done && frame_err) || (Rx_Done && pd) || (frame_err && pe)) viol++;
    if (mid_frame && !busy) busy_low++;
    pd = Rx_Done;
    pe = frame_err;
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input int bp, input logic stop);
    uart_rx = 1'b0;
    wait_clk(10);
    mid_frame = 1'b1;
    wait_clk(bp - 10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clk(bp);
    end
    mid_frame = 1'b0;
    uart_rx = stop;
    wait_clk(bp);
    uart_rx = 1'b1;
  endtask
  task automatic test_reset;
    #10 rstn = 1'b0;
    wait_clk(3);
    total++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else passed++;
    total++; if (Rx_Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Rx_Done); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    rstn = 1'b1;
    wait_clk(10);
  endtask
  task automatic test_basic;
    Baudrate_Set = 3'd4;
    busy_low = 0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, BP4, 1'b1);
    wait_clk(20);
    total++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (data !== 8'hA5) $display("FAIL basic_data: got %h expected a5", data); else passed++;
    total++; if (err_cnt - e0 !== 0) $display("FAIL basic_ferr_count: got %0d expected 0", err_cnt - e0); else passed++;
    total++; if (busy_low !== 0) $display("FAIL basic_busy_frame: got %0d low cycles expected 0", busy_low); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %b expected 0", busy); else passed++;
  endtask
  task automatic test_back_to_back;
    Baudrate_Set = 3'd0;
    wait_clk(10);
    d0 = done_cnt;
    send_frame(8'h00, BP0, 1'b1);
    total++; if (done_cnt - d0 !== 1) $display("FAIL b2b_done1: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (data !== 8'h00) $display("FAIL b2b_data1: got %h expected 00", data); else passed++;
    send_frame(8'hFF, BP0, 1'b1);
    total++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done2: got %0d expected 2", done_cnt - d0); else passed++;
    total++; if (data !== 8'hFF) $display("FAIL b2b_data2: got %h expected ff", data); else passed++;
    wait_clk(20);
  endtask
  task automatic test_frame_err;
    Baudrate_Set = 3'd4;
    wait_clk(10);
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, BP4, 1'b0);
    wait_clk(20);
    total++; if (err_cnt - e0 !== 1) $display("FAIL ferr_count: got %0d expected 1", err_cnt - e0); else passed++;
    total++; if (done_cnt - d0 !== 0) $display("FAIL ferr_done: got %0d expected 0", done_cnt - d0); else passed++;
    total++; if (data !== 8'hFF) $display("FAIL ferr_data_kept: got %h expected ff", data); else passed++;
    send_frame(8'h81, BP4, 1'b1);
    wait_clk(20);
    total++; if (done_cnt - d0 !== 1) $display("FAIL ferr_next_done: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (data !== 8'h81) $display("FAIL ferr_next_data: got %h expected 81", data); else passed++;
  endtask
  task automatic test_glitch;
    Baudrate_Set = 3'd4;
    d0 = done_cnt; e0 = err_cnt;
    uart_rx = 1'b0;
    wait_clk(20);
    uart_rx = 1'b1;
    wait_clk(200);
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b expected 0", busy); else passed++;
    total++; if (done_cnt - d0 !== 0) $display("FAIL glitch_done: got %0d expected 0", done_cnt - d0); else passed++;
    total++; if (err_cnt - e0 !== 0) $display("FAIL glitch_ferr: got %0d expected 0", err_cnt - e0); else passed++;
    send_frame(8'h5A, BP4, 1'b1);
    wait_clk(20);
    total++; if (done_cnt - d0 !== 1) $display("FAIL glitch_next_done: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (data !== 8'h5A) $display("FAIL glitch_next_data: got %h expected 5a", data); else passed++;
  endtask
  task automatic test_baud_change;
    Baudrate_Set = 3'd4;
    d0 = done_cnt;
    fork
      send_frame(8'h96, BP4, 1'b1);
      begin
        wait_clk(300);
        Baudrate_Set = 3'd0;
      end
    join
    wait_clk(20);
    total++; if (done_cnt - d0 !== 1) $display("FAIL baud_mid_done: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (data !== 8'h96) $display("FAIL baud_mid_data: got %h expected 96", data); else passed++;
    send_frame(8'h69, BP0, 1'b1);
    wait_clk(20);
    total++; if (done_cnt - d0 !== 2) $display("FAIL baud_next_done: got %0d expected 2", done_cnt - d0); else passed++;
    total++; if (data !== 8'h69) $display("FAIL baud_next_data: got %h expected 69", data); else passed++;
  endtask
  task automatic test_reset_mid_frame;
    Baudrate_Set = 3'd4;
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_frame(8'hF5, BP4, 1'b1);
      begin
        wait_clk(350);
        total++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", busy); else passed++;
        rstn = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy_async: got %b expected 0", busy); else passed++;
        total++; if (data !== 8'h00) $display("FAIL rst_mid_data_async: got %h expected 00", data); else passed++;
        wait_clk(60);
        rstn = 1'b1;
      end
    join
    wait_clk(20);
    total++; if (done_cnt - d0 !== 0) $display("FAIL rst_mid_done: got %0d expected 0", done_cnt - d0); else passed++;
    total++; if (err_cnt - e0 !== 0) $display("FAIL rst_mid_ferr: got %0d expected 0", err_cnt - e0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy_after: got %b expected 0", busy); else passed++;
    send_frame(8'hC3, BP4, 1'b1);
    wait_clk(20);
    total++; if (done_cnt - d0 !== 1) $display("FAIL rst_next_done: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (data !== 8'hC3) $display("FAIL rst_next_data: got %h expected c3", data); else passed++;
  endtask
  task automatic test_pulse_rules;
    total++; if (viol !== 0) $display("FAIL pulse_rules: got %0d violations expected 0", viol); else passed++;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_frame_err;
    test_glitch;
    test_baud_change;
    test_reset_mid_frame;
    test_pulse_rules;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
